// File: rtl/ls191_vecgen.sv
// Vector sequencer for a '191-style 4-bit up/down counter: drives the counter pins,
// tracks the expected count and tallies vectors whose q/max-min/ripple outputs disagree.
module ls191_vecgen #(
    parameter logic [3:0] LOAD_VAL    = 4'd5,
    parameter int         COUNT_LEN   = 18,
    parameter int         HOLD_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       dut_clk,
    output logic       dut_ld,
    output logic       dut_g,
    output logic       dut_down_up,
    output logic [3:0] dut_data,
    input  logic [3:0] dut_q,
    input  logic       dut_mm,
    input  logic       dut_rip,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] err_vec
);

    typedef enum logic [2:0] {IDLE, LOAD, UP, HOLD, DOWN, FINAL, DONE} state_t;

    localparam logic [7:0] UP_LAST   = 8'(COUNT_LEN - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic       phase_q, phase_d;
    logic [7:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] exp_q, exp_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] err_vec_q, err_vec_d;

    logic exp_mm;
    logic mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 1'b0;
            vec_q     <= 8'd0;
            cnt_q     <= 8'd0;
            exp_q     <= 4'd0;
            err_cnt_q <= 8'd0;
            err_vec_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
            err_vec_q <= err_vec_d;
        end
    end

    // Pins depend only on the phase of the run; HOLD shares the idle levels.
    always_comb begin
        dut_ld      = 1'b1;
        dut_g       = 1'b1;
        dut_down_up = 1'b0;
        dut_data    = 4'd0;
        case (state_q)
            LOAD: begin
                dut_ld   = 1'b0;
                dut_data = LOAD_VAL;
            end
            UP:    dut_g = 1'b0;
            DOWN: begin
                dut_g       = 1'b0;
                dut_down_up = 1'b1;
            end
            FINAL: dut_down_up = 1'b1;
            default: ;
        endcase
    end

    assign dut_clk  = phase_q;
    // Sampled while dut_clk is low, so ripple-clock is simply the inverse of max/min.
    assign exp_mm   = dut_down_up ? (exp_q == 4'd0) : (exp_q == 4'd15);
    assign mismatch = (dut_q != exp_q) || (dut_mm != exp_mm) || (dut_rip != ~exp_mm);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        err_cnt_d = err_cnt_q;
        err_vec_d = err_vec_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    phase_d   = 1'b0;
                    vec_d     = 8'd0;
                    cnt_d     = 8'd0;
                    exp_d     = LOAD_VAL;
                    err_cnt_d = 8'd0;
                    err_vec_d = 8'hFF;
                end
            end
            default: begin
                if (!phase_q) begin
                    if (mismatch) begin
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        if (err_cnt_q == 8'd0)  err_vec_d = vec_q;
                    end
                    if (state_q == FINAL) state_d = DONE;
                    else                  phase_d = 1'b1;
                    if (state_q == UP)        exp_d = exp_q + 4'd1;
                    else if (state_q == DOWN) exp_d = exp_q - 4'd1;
                end else begin
                    phase_d = 1'b0;
                    vec_d   = vec_q + 8'd1;
                    cnt_d   = cnt_q + 8'd1;
                    case (state_q)
                        LOAD: begin
                            state_d = UP;
                            cnt_d   = 8'd0;
                        end
                        UP: if (cnt_q == UP_LAST) begin
                            state_d = (HOLD_CYCLES == 0) ? DOWN : HOLD;
                            cnt_d   = 8'd0;
                        end
                        HOLD: if (cnt_q == HOLD_LAST) begin
                            state_d = DOWN;
                            cnt_d   = 8'd0;
                        end
                        DOWN: if (cnt_q == UP_LAST) begin
                            state_d = FINAL;
                            cnt_d   = 8'd0;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign pass    = done && (err_cnt_q == 8'd0);
    assign err_cnt = err_cnt_q;
    assign err_vec = err_vec_q;

endmodule

// File: tb/tb_ls191_vecgen.sv
// Bench for ls191_vecgen: two sequencers (default and minimal lengths), each driving a
// behavioural '191 with selectable output faults; results scored against an arithmetic model.
module tb_ls191_vecgen;

    localparam logic [3:0] LV = 4'd5;

    typedef struct packed {
        logic       ld;
        logic       g;
        logic       du;
        logic [3:0] data;
    } pins_t;

    typedef struct packed {
        logic [31:0] blen;
        logic [7:0]  ec;
        logic [7:0]  ev;
        logic        ps;
    } res_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] dclk, dld, dg, ddu, dmm, drip, busy, done, pass;
    logic [3:0] ddata [2];
    logic [3:0] dq    [2];
    logic [7:0] ecnt  [2];
    logic [7:0] evec  [2];
    int         fault [2];
    logic [1:0] sbit  [2];
    logic [1:0] sval;

    pins_t pq [2][$];
    res_t  rq [2][$];
    int    n_cmp;
    int    n_fail;

    for (genvar G = 0; G < 2; G++) begin : g_inst
        localparam int CL = (G == 0) ? 18 : 1;
        localparam int HC = (G == 0) ? 3 : 0;

        logic [3:0] cnt_m = 4'd0;
        logic [3:0] qo;
        logic [3:0] qf;
        logic       mm_i;

        ls191_vecgen #(.LOAD_VAL(LV), .COUNT_LEN(CL), .HOLD_CYCLES(HC)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start[G]),
            .dut_clk    (dclk[G]),
            .dut_ld     (dld[G]),
            .dut_g      (dg[G]),
            .dut_down_up(ddu[G]),
            .dut_data   (ddata[G]),
            .dut_q      (dq[G]),
            .dut_mm     (dmm[G]),
            .dut_rip    (drip[G]),
            .busy       (busy[G]),
            .done       (done[G]),
            .pass       (pass[G]),
            .err_cnt    (ecnt[G]),
            .err_vec    (evec[G])
        );

        // Ideal counter: load is level-sensitive, counting on the rising counter clock.
        always @(posedge dclk[G]) begin
            if (!dld[G])     cnt_m <= ddata[G];
            else if (!dg[G]) cnt_m <= ddu[G] ? cnt_m - 4'd1 : cnt_m + 4'd1;
        end
        assign qo   = !dld[G] ? ddata[G] : cnt_m;
        assign mm_i = ddu[G] ? (qo == 4'd0) : (qo == 4'd15);
        always_comb begin
            qf = qo;
            if (fault[G] == 1)      qf[0]       = 1'b0;
            else if (fault[G] == 3) qf[sbit[G]] = sval[G];
        end
        assign dq[G]   = qf;
        assign dmm[G]  = (fault[G] == 2) ? 1'b0 : mm_i;
        assign drip[G] = ~(mm_i & ~dclk[G]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_q(int k, int n, int h);
        int v;
        if (k == 0)              v = LV;
        else if (k <= n)         v = LV + k - 1;
        else if (k <= n + h)     v = LV + n;
        else if (k <= 2 * n + h) v = LV + n - (k - n - h - 1);
        else                     v = LV;
        return 4'(v & 15);
    endfunction

    function automatic pins_t ref_pins(int k, int n, int h);
        pins_t p;
        p.ld   = (k != 0);
        p.du   = (k > n + h);
        p.g    = !((k >= 1 && k <= n) || (k > n + h && k <= 2 * n + h));
        p.data = (k == 0) ? LV : 4'd0;
        return p;
    endfunction

    function automatic res_t ref_res(int n, int h, int f, logic [1:0] sb, logic sv);
        res_t       r;
        int         nv;
        logic [3:0] q, oq;
        logic       mm, omm;
        nv     = 2 * n + h + 2;
        r.blen = 32'(2 * nv - 1);
        r.ec   = 8'd0;
        r.ev   = 8'hFF;
        for (int k = 0; k < nv; k++) begin
            q   = ref_q(k, n, h);
            mm  = (k > n + h) ? (q == 4'd0) : (q == 4'd15);
            oq  = q;
            omm = mm;
            if (f == 1)      oq[0]  = 1'b0;
            else if (f == 2) omm    = 1'b0;
            else if (f == 3) oq[sb] = sv;
            if (oq != q || omm != mm) begin
                if (r.ec == 8'd0) r.ev = 8'(k);
                if (r.ec != 8'hFF) r.ec = r.ec + 8'd1;
            end
        end
        r.ps = (r.ec == 8'd0);
        return r;
    endfunction

    task automatic push_run(int i, int f, logic [1:0] sb, logic sv);
        int n, h;
        n = (i == 0) ? 18 : 1;
        h = (i == 0) ? 3 : 0;
        fault[i] = f;
        sbit[i]  = sb;
        sval[i]  = sv;
        for (int k = 0; k < 2 * n + h + 2; k++) pq[i].push_back(ref_pins(k, n, h));
        rq[i].push_back(ref_res(n, h, f, sb, sv));
    endtask

    task automatic run(int i, int f, logic [1:0] sb, logic sv, int ig1, int ig2);
        int cyc;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        push_run(i, f, sb, sv);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        chk($sformatf("start_busy%0d", i), 32'(busy[i]), 32'd1);
        chk($sformatf("start_done%0d", i), 32'(done[i]), 32'd0);
        chk($sformatf("start_errcnt%0d", i), 32'(ecnt[i]), 32'd0);
        chk($sformatf("start_errvec%0d", i), 32'(evec[i]), 32'hFF);
        cyc = 1;
        while (!done[i] && cyc < 1000) begin
            if (cyc == ig1 || cyc == ig2) start[i] = 1'b1;
            @(posedge clk); #1;
            start[i] = 1'b0;
            cyc++;
        end
        if (!done[i]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_timeout%0d: done=%0b after %0d cycles, expected done=1", i, done[i], cyc);
        end
        @(negedge clk); #1;
    endtask

    task automatic chk_reset(int i, string tag);
        chk({tag, "_busy"},   32'(busy[i]), 32'd0);
        chk({tag, "_done"},   32'(done[i]), 32'd0);
        chk({tag, "_pass"},   32'(pass[i]), 32'd0);
        chk({tag, "_errcnt"}, 32'(ecnt[i]), 32'd0);
        chk({tag, "_errvec"}, 32'(evec[i]), 32'hFF);
        chk({tag, "_pins"}, 32'({dclk[i], dld[i], dg[i], ddu[i], ddata[i]}), 32'({1'b0, 1'b1, 1'b1, 1'b0, 4'd0}));
    endtask

    // Monitor: each low-clock busy cycle presents one vector; busy falling presents the result.
    initial begin : monitor
        logic [1:0] prev_busy;
        int         bcnt [2];
        pins_t      p;
        res_t       r;
        prev_busy = 2'b00;
        bcnt[0]   = 0;
        bcnt[1]   = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    prev_busy[i] = 1'b0;
                    bcnt[i]      = 0;
                end else begin
                    if (busy[i]) begin
                        if (!prev_busy[i]) bcnt[i] = 0;
                        bcnt[i]++;
                        if (!dclk[i]) begin
                            if (pq[i].size() == 0) begin
                                n_cmp++;
                                n_fail++;
                                $display("FAIL pins%0d: got vector %0h, expected none", i,
                                         {dld[i], dg[i], ddu[i], ddata[i]});
                            end else begin
                                p = pq[i].pop_front();
                                chk($sformatf("pins%0d", i), 32'({dld[i], dg[i], ddu[i], ddata[i]}), 32'(p));
                            end
                        end
                    end else if (prev_busy[i]) begin
                        if (rq[i].size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL result%0d: got completion, expected none", i);
                        end else begin
                            r = rq[i].pop_front();
                            chk($sformatf("busy_len%0d", i), 32'(bcnt[i]), r.blen);
                            chk($sformatf("done%0d", i), 32'(done[i]), 32'd1);
                            chk($sformatf("err_cnt%0d", i), 32'(ecnt[i]), 32'(r.ec));
                            chk($sformatf("err_vec%0d", i), 32'(evec[i]), 32'(r.ev));
                            chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(r.ps));
                            chk($sformatf("idle_pins%0d", i), 32'({dclk[i], dld[i], dg[i], ddu[i], ddata[i]}),
                                32'({1'b0, 1'b1, 1'b1, 1'b0, 4'd0}));
                        end
                    end
                    prev_busy[i] = busy[i];
                end
            end
        end
    end

    initial begin : stimulus
        int cyc;
        n_cmp    = 0;
        n_fail   = 0;
        start    = 2'b00;
        fault[0] = 0;
        fault[1] = 0;
        sbit[0]  = 2'd0;
        sbit[1]  = 2'd0;
        sval     = 2'b00;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");
        @(negedge clk); rst_n = 1'b1;

        // Ideal counter with start pulses during the run, then reruns from DONE with faults.
        run(0, 0, 2'd0, 1'b0, 10, 50);
        run(0, 1, 2'd0, 1'b0, -1, -1);
        run(0, 2, 2'd0, 1'b0, -1, -1);
        for (int j = 0; j < 4; j++)
            run(0, 3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);

        // Abort a run mid-way with reset, then confirm a fresh run completes.
        @(posedge clk); #1;
        push_run(0, 0, 2'd0, 1'b0);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        #1 rst_n = 1'b0;
        pq[0].delete();
        rq[0].delete();
        #1;
        chk_reset(0, "abort");
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run(0, 0, 2'd0, 1'b0, -1, -1);

        run(1, 0, 2'd0, 1'b0, -1, -1);
        run(1, 2, 2'd0, 1'b0, 3, -1);
        run(1, 3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("leftover_vec%0d", i), 32'(pq[i].size()), 32'd0);
            chk($sformatf("leftover_res%0d", i), 32'(rq[i].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ls191_vecgen.md
# ls191_vecgen

Self-checking stimulus/response sequencer for a 4-bit synchronous up/down counter with asynchronous parallel load ('191 pinout). It is the driving end of the counter's pin interface. It generates the counter clock, load, enable, direction and data pins. It models the expected count and compares the counter's q, max/min and ripple-clock outputs every vector. It sits between the vector-generation top level and the counter under test, and reports pass/fail plus the first failing vector.

## Interface
Parameters:
- LOAD_VAL, 4'd5: value presented on the data pins during the load vector.
- COUNT_LEN, 18: number of up vectors, and separately the number of down vectors (1..100).
- HOLD_CYCLES, 3: number of disabled (g=1) vectors between the up and down phases (0..50).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  run request; sampled only when not busy.
- dut_clk  output  1  counter clock pin.
- dut_ld  output  1  active-low load pin.
- dut_g  output  1  active-low count-enable pin.
- dut_down_up  output  1  direction pin: 1 = down, 0 = up.
- dut_data  output  4  data pins {d,c,b,a}.
- dut_q  input  4  counter outputs {qd,qc,qb,qa}.
- dut_mm  input  1  max/min output.
- dut_rip  input  1  ripple-clock output.
- busy  output  1  sequence running.
- done  output  1  sequence complete; held until next start.
- pass  output  1  valid when done; 1 iff err_cnt == 0.
- err_cnt  output  8  mismatching vectors, saturates at 255.
- err_vec  output  8  index of first mismatching vector; 8'hFF = none.

## Operation
- FSM states: IDLE, LOAD, UP, HOLD, DOWN, FINAL, DONE.
- start is honoured in IDLE or DONE. Taking it clears err_cnt, sets err_vec to FF, clears done/pass and enters LOAD. start is ignored while busy.
- One vector = phase A (dut_clk=0, new pin values applied) followed by phase B (dut_clk=1; the counter's rising edge occurs at the start of B). Pins are constant across A and B.
- LOAD, vector 0: ld=0, g=1, down_up=0, data=LOAD_VAL. Model exp=LOAD_VAL.
- UP, vectors 1..COUNT_LEN: ld=1, g=0, down_up=0, data=0. exp=exp+1 mod 16 at each B.
- HOLD, next HOLD_CYCLES vectors: g=1, down_up=0. exp unchanged.
- DOWN, next COUNT_LEN vectors: g=0, down_up=1. exp=exp-1 mod 16 at each B.
- FINAL, one vector: phase A only, with g=1 and down_up=1. Check, then go to DONE.
- Expected flags for each check use the current vector's down_up:
  - exp_mm = (down_up=0 & exp=15) | (down_up=1 & exp=0).
  - exp_rip = ~exp_mm, because dut_clk is low at sampling.
- A mismatch on any of q, mm or rip counts as one vector error. On the first error, err_vec captures the vector index.
- DONE: busy=0, done=1, pass=(err_cnt==0). Pins are held at their idle values.
- Idle pin values: dut_clk=0, ld=1, g=1, down_up=0, data=0.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, idle pin values, busy=0, done=0, pass=0, err_cnt=0, err_vec=8'hFF.
- Reset during a run aborts it at once. No partial result is retained.
- busy rises on the clk after start is sampled and lasts exactly 2*(V-1)+1 cycles, where V = 2*COUNT_LEN + HOLD_CYCLES + 2. done rises on the cycle busy falls.
- Check sampling happens at the clk edge that ends phase A of every vector, including FINAL. The exp value sampled reflects all prior B edges.
- The vector index is 8 bits and counts from 0 at LOAD. Parameter limits keep V ≤ 255.
- Wrap-around: exp wraps 15→0 in UP and 0→15 in DOWN, with no error.
- err_cnt holds at 255 once saturated.

## Test plan
- Ideal behavioural '191 model, defaults:
  - busy lasts 81 cycles, then done=1, pass=1, err_cnt=0, err_vec=FF.
  - q sequence seen at checks: 5,5,6,…,15,0,…,6 in UP. It holds at 7 through HOLD, then counts down through 0→15.
- Counter model with qa stuck at 0, LOAD_VAL=5:
  - mismatch at vector 0, so err_vec=0 and pass=0.
  - err_cnt equals the number of checks with exp odd.
- Model with mm stuck at 0:
  - first error at vector 11 (exp=15 going up), err_vec=11, pass=0.
- Assert rst_n low at cycle 30 of a run, release, then pulse start:
  - outputs return to reset values immediately.
  - the new run completes in 81 cycles with pass=1.
- Pulse start again at cycles 10 and 50 of a run:
  - both pulses are ignored and the run finishes normally.
  - a start in DONE clears done/err and reruns.
- COUNT_LEN=1, HOLD_CYCLES=0:
  - V=4, busy lasts 7 cycles.
  - checks expect q=5, 5, 6, then 5 in FINAL.
